// File: rtl/keypad_entry_ctrl_if.sv
// Key/command inputs and entry/commit outputs of keypad_entry_ctrl.
// master drives keys and commands; slave (the controller) drives the entry state.
interface keypad_entry_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned EW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);

  logic [9:0]    keypad;
  logic          enter;
  logic          clear;
  logic [EW-1:0] entry_bcd;
  logic [CW-1:0] digit_cnt;
  logic          entering;
  logic [EW-1:0] value_bcd;
  logic          value_valid;
  logic          multi_key_err;
  logic          timed_out;

  modport master (
    output keypad, enter, clear,
    input  entry_bcd, digit_cnt, entering, value_bcd, value_valid, multi_key_err, timed_out
  );

  modport slave (
    input  keypad, enter, clear,
    output entry_bcd, digit_cnt, entering, value_bcd, value_valid, multi_key_err, timed_out
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Builds a multi-digit BCD entry from single-cycle key pulses and commits it on enter.
// Define KEYPAD_ENTRY_TIMEOUT_EN to build the inactivity timer that abandons a stale entry.
module keypad_entry_ctrl #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  keypad_entry_ctrl_if.slave bus
);
  localparam int unsigned EW = 4 * NUM_DIGITS;
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("keypad_entry_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {
    IDLE,
    ENTRY
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] value_q, value_d;
  logic          valid_q, valid_d;
  logic          mk_q, mk_d;

  logic [3:0] key_count;
  logic [3:0] digit;
  logic       one_key;

  always_comb begin
    key_count = '0;
    digit     = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bus.keypad[i]) begin
        key_count = key_count + 4'd1;
        digit     = 4'(i);
      end
    end
    one_key = (key_count == 4'd1);
  end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    mk_d    = (key_count > 4'd1);
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    timer_d = timer_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        timer_d = '0;
`endif
        if (one_key) begin
          entry_d = EW'(digit);
          cnt_d   = CW'(1);
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (bus.clear) begin
          state_d = IDLE;
          entry_d = '0;
          cnt_d   = '0;
        end else if (bus.enter) begin
          value_d = entry_q;
          valid_d = 1'b1;
          state_d = IDLE;
          entry_d = '0;
          cnt_d   = '0;
        end else if (one_key) begin
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
          timer_d = '0;
`endif
          // A full buffer swallows the digit silently but it still counts as activity.
          if (cnt_q < CW'(NUM_DIGITS)) begin
            entry_d = (entry_q << 4) | EW'(digit);
            cnt_d   = cnt_q + CW'(1);
          end
        end
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        else if (timer_q == TMAX) begin
          state_d = IDLE;
          entry_d = '0;
          cnt_d   = '0;
          timer_d = '0;
          to_d    = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        entry_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      mk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      mk_q    <= mk_d;
    end
  end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      to_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      to_q    <= to_d;
    end
  end

  assign bus.timed_out = to_q;
`else
  assign bus.timed_out = 1'b0;
`endif

  assign bus.entry_bcd     = entry_q;
  assign bus.digit_cnt     = cnt_q;
  assign bus.entering      = (state_q == ENTRY);
  assign bus.value_bcd     = value_q;
  assign bus.value_valid   = valid_q;
  assign bus.multi_key_err = mk_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl (NUM_DIGITS=4, TIMEOUT_CYCLES=8), both macro builds.
module tb_keypad_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  keypad_entry_ctrl_if #(.NUM_DIGITS(4)) bus ();

  keypad_entry_ctrl #(
    .NUM_DIGITS    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Inputs change at the falling edge; outputs are sampled at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    bus.keypad = '0;
    bus.enter  = 1'b0;
    bus.clear  = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic press(input int d);
    bus.keypad = 10'(1 << d);
    step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rst_entry", 32'(bus.entry_bcd), 32'h0);
    chk("rst_cnt", 32'(bus.digit_cnt), 32'h0);
    chk("rst_entering", 32'(bus.entering), 32'h0);
    chk("rst_value", 32'(bus.value_bcd), 32'h0);
    chk("rst_valid", 32'(bus.value_valid), 32'h0);
    chk("rst_mk", 32'(bus.multi_key_err), 32'h0);
    chk("rst_to", 32'(bus.timed_out), 32'h0);
    bus.enter = 1'b1;
    step();
    chk("idle_enter_novalid", 32'(bus.value_valid), 32'h0);
    chk("idle_enter_noentry", 32'(bus.entering), 32'h0);
  endtask

  task automatic test_basic_entry();
    press(1);
    chk("e1_entry", 32'(bus.entry_bcd), 32'h0001);
    chk("e1_cnt", 32'(bus.digit_cnt), 32'd1);
    chk("e1_entering", 32'(bus.entering), 32'h1);
    press(2);
    chk("e2_entry", 32'(bus.entry_bcd), 32'h0012);
    chk("e2_cnt", 32'(bus.digit_cnt), 32'd2);
    press(3);
    chk("e3_entry", 32'(bus.entry_bcd), 32'h0123);
    chk("e3_cnt", 32'(bus.digit_cnt), 32'd3);
    bus.enter = 1'b1;
    step();
    chk("commit_value", 32'(bus.value_bcd), 32'h0123);
    chk("commit_valid", 32'(bus.value_valid), 32'h1);
    chk("commit_entry_clr", 32'(bus.entry_bcd), 32'h0);
    chk("commit_cnt_clr", 32'(bus.digit_cnt), 32'h0);
    chk("commit_idle", 32'(bus.entering), 32'h0);
    step();
    chk("valid_one_cycle", 32'(bus.value_valid), 32'h0);
    chk("value_held", 32'(bus.value_bcd), 32'h0123);
  endtask

  task automatic test_overflow();
    press(9); press(8); press(7); press(6);
    chk("full_entry", 32'(bus.entry_bcd), 32'h9876);
    press(5);
    chk("ovf_entry", 32'(bus.entry_bcd), 32'h9876);
    chk("ovf_cnt", 32'(bus.digit_cnt), 32'd4);
    chk("ovf_no_mk", 32'(bus.multi_key_err), 32'h0);
    bus.enter = 1'b1;
    step();
    chk("ovf_value", 32'(bus.value_bcd), 32'h9876);
    chk("ovf_valid", 32'(bus.value_valid), 32'h1);
  endtask

  task automatic test_multi_key();
    press(1);
    bus.keypad = 10'b0000010100;
    step();
    chk("mk_strobe", 32'(bus.multi_key_err), 32'h1);
    chk("mk_entry", 32'(bus.entry_bcd), 32'h0001);
    chk("mk_cnt", 32'(bus.digit_cnt), 32'd1);
    step();
    chk("mk_one_cycle", 32'(bus.multi_key_err), 32'h0);
    bus.clear = 1'b1;
    step();
    chk("mk_clear_idle", 32'(bus.entering), 32'h0);
  endtask

  task automatic test_clear_enter();
    press(4); press(2);
    chk("ce_entry", 32'(bus.entry_bcd), 32'h0042);
    bus.clear = 1'b1;
    bus.enter = 1'b1;
    step();
    chk("ce_idle", 32'(bus.entering), 32'h0);
    chk("ce_novalid", 32'(bus.value_valid), 32'h0);
    chk("ce_value_kept", 32'(bus.value_bcd), 32'h9876);
    chk("ce_entry_clr", 32'(bus.entry_bcd), 32'h0);
    press(6);
    bus.clear  = 1'b1;
    bus.keypad = 10'(1 << 3);
    step();
    chk("clr_beats_digit", 32'(bus.entry_bcd), 32'h0);
    chk("clr_digit_idle", 32'(bus.entering), 32'h0);
  endtask

  task automatic test_back_to_back();
    press(7);
    bus.enter = 1'b1;
    step();
    chk("b2b_value", 32'(bus.value_bcd), 32'h0007);
    press(3);
    chk("b2b_valid_low", 32'(bus.value_valid), 32'h0);
    chk("b2b_new_entry", 32'(bus.entry_bcd), 32'h0003);
    chk("b2b_entering", 32'(bus.entering), 32'h1);
    bus.clear = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    int first_to;
    int to_count;
    first_to = -1;
    to_count = 0;
    press(5);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.timed_out === 1'b1) begin
        to_count++;
        if (first_to < 0) first_to = i;
      end
    end
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    chk("to_count", 32'(to_count), 32'd1);
    chk("to_latency", 32'(first_to), 32'd8);
    chk("to_idle", 32'(bus.entering), 32'h0);
    chk("to_entry_clr", 32'(bus.entry_bcd), 32'h0);
`else
    chk("noto_count", 32'(to_count), 32'd0);
    chk("noto_entering", 32'(bus.entering), 32'h1);
    chk("noto_entry", 32'(bus.entry_bcd), 32'h0005);
    bus.clear = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_mid_entry();
    press(3);
    rst = 1'b1;
    step();
    bus.enter = 1'b1;
    step();
    chk("rm_entry", 32'(bus.entry_bcd), 32'h0);
    chk("rm_cnt", 32'(bus.digit_cnt), 32'h0);
    chk("rm_entering", 32'(bus.entering), 32'h0);
    chk("rm_value", 32'(bus.value_bcd), 32'h0);
    chk("rm_novalid", 32'(bus.value_valid), 32'h0);
  endtask

  initial begin
    bus.keypad = '0;
    bus.enter  = 1'b0;
    bus.clear  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_entry();
    test_overflow();
    test_multi_key();
    test_clear_enter();
    test_back_to_back();
    test_timeout();
    test_reset_mid_entry();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
